// File: rtl/somador_serial_param_if.sv
// Handshake and operand/result bundle for somador_serial_param.
// The requester uses the master modport and the adder uses the slave modport.
interface somador_serial_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/somador_serial_param.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, start/busy/done handshake.
// Optional macro SOMADOR_SAT_EN clamps the result to the signed limits on overflow.
module somador_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    somador_serial_param_if.slave  bus
);
    localparam int NUM   = WIDTH / DIGIT;
    localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM - 1);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("somador_serial_param: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] sreg;
    logic             carry;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;

    logic [DIGIT-1:0]       dsum;
    logic [DIGIT:0]         c;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0]       sum_next;
    logic                   ovf_next;
    logic [WIDTH-1:0]       result;

`ifdef SOMADOR_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             ov,
                                                  input logic             sign);
        logic signed [WIDTH-1:0] smax;
        logic signed [WIDTH-1:0] smin;
        smax = {1'b0, {(WIDTH-1){1'b1}}};
        smin = {1'b1, {(WIDTH-1){1'b0}}};
        if (!ov) return raw;
        return sign ? smin : smax;
    endfunction
`endif

    // One DIGIT-wide ripple-carry slice; c[DIGIT-1] is the carry into the digit's top bit.
    always_comb begin
        c    = '0;
        dsum = '0;
        c[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = areg[i] ^ breg[i] ^ c[i];
            c[i+1]   = (areg[i] & breg[i]) | (c[i] & (areg[i] ^ breg[i]));
        end
    end

    always_comb begin
        cat      = {dsum, sreg};
        sum_next = cat[WIDTH+DIGIT-1:DIGIT];
        ovf_next = c[DIGIT-1] ^ c[DIGIT];
`ifdef SOMADOR_SAT_EN
        // On the last digit areg[DIGIT-1] is the operand sign, shared by both operands when ovf is set.
        result   = saturate(sum_next, ovf_next, areg[DIGIT-1]);
`else
        result   = sum_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            areg   <= '0;
            breg   <= '0;
            sreg   <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // Subtraction becomes a + ~b + ~cin.
                        areg   <= bus.a;
                        breg   <= bus.b ^ {WIDTH{bus.sub}};
                        carry  <= bus.cin ^ bus.sub;
                        sreg   <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    areg  <= areg >> DIGIT;
                    breg  <= breg >> DIGIT;
                    sreg  <= sum_next;
                    carry <= c[DIGIT];
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        s_r    <= result;
                        cout_r <= c[DIGIT];
                        ovf_r  <= ovf_next;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.s    = s_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_somador_serial_param.sv
// Bench for somador_serial_param: three instances (DIGIT = 1, 4, 8) at WIDTH = 8,
// directed test-plan steps followed by random operations against an integer-arithmetic model.
module tb_somador_serial_param;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    somador_serial_param_if #(.WIDTH(W)) bus1 ();
    somador_serial_param_if #(.WIDTH(W)) bus4 ();
    somador_serial_param_if #(.WIDTH(W)) bus8 ();

    somador_serial_param #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    somador_serial_param #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    somador_serial_param #(.WIDTH(W), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic sb,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        case (sel)
            1: begin bus1.start = st; bus1.sub = sb; bus1.a = a; bus1.b = b; bus1.cin = ci; end
            8: begin bus8.start = st; bus8.sub = sb; bus8.a = a; bus8.b = b; bus8.cin = ci; end
            default: begin bus4.start = st; bus4.sub = sb; bus4.a = a; bus4.b = b; bus4.cin = ci; end
        endcase
    endtask

    function automatic logic f_busy(input int sel);
        case (sel) 1: return bus1.busy; 8: return bus8.busy; default: return bus4.busy; endcase
    endfunction
    function automatic logic f_done(input int sel);
        case (sel) 1: return bus1.done; 8: return bus8.done; default: return bus4.done; endcase
    endfunction
    function automatic logic [7:0] f_s(input int sel);
        case (sel) 1: return bus1.s; 8: return bus8.s; default: return bus4.s; endcase
    endfunction
    function automatic logic f_cout(input int sel);
        case (sel) 1: return bus1.cout; 8: return bus8.cout; default: return bus4.cout; endcase
    endfunction
    function automatic logic f_ovf(input int sel);
        case (sel) 1: return bus1.ovf; 8: return bus8.ovf; default: return bus4.ovf; endcase
    endfunction

    // Reference: exact integer result, then wrap/clamp to 8 bits.
    function automatic void model(input logic sb, input logic [7:0] a, input logic [7:0] b,
                                  input logic ci, output logic [7:0] s,
                                  output logic co, output logic ov);
        int ia, ib, ua, ub, ic, ur, r;
        ia = $signed(a);
        ib = $signed(b);
        ua = int'(a);
        ub = int'(b);
        ic = ci ? 1 : 0;
        if (!sb) begin
            ur = ua + ub + ic;
            r  = ia + ib + ic;
            co = (ur > 255);
        end else begin
            ur = ua - ub - ic;
            r  = ia - ib - ic;
            co = (ur >= 0);
        end
        ov = (r > 127) || (r < -128);
        s  = ur[7:0];
`ifdef SOMADOR_SAT_EN
        if (ov) s = (r > 127) ? 8'h7F : 8'h80;
`endif
    endfunction

    // Runs one operation, checking busy/done per cycle and the result after done.
    task automatic do_op(input int sel, input string tag, input logic sb,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        int num;
        logic [7:0] es;
        logic ec, eo;
        num = W / sel;
        model(sb, a, b, ci, es, ec, eo);
        @(negedge clk);
        drive(sel, 1'b1, sb, a, b, ci);
        for (int k = 1; k <= num + 1; k++) begin
            @(negedge clk);
            if (k == 1) drive(sel, 1'b0, ~sb, 8'($urandom), 8'($urandom), ~ci);
            chk($sformatf("%s_busy_c%0d", tag, k), 32'(f_busy(sel)), 32'(k <= num));
            chk($sformatf("%s_done_c%0d", tag, k), 32'(f_done(sel)), 32'(k == num + 1));
        end
        chk({tag, "_s"},    32'(f_s(sel)),    32'(es));
        chk({tag, "_cout"}, 32'(f_cout(sel)), 32'(ec));
        chk({tag, "_ovf"},  32'(f_ovf(sel)),  32'(eo));
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(f_busy(sel)), 32'd0);
        chk({tag, "_idle_done"}, 32'(f_done(sel)), 32'd0);
        chk({tag, "_hold_s"},    32'(f_s(sel)),    32'(es));
    endtask

    initial begin
        int ndone;
        int sel;
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = (i == 0) ? 1 : ((i == 1) ? 4 : 8);
            chk($sformatf("rst_busy_d%0d", sel), 32'(f_busy(sel)), 32'd0);
            chk($sformatf("rst_done_d%0d", sel), 32'(f_done(sel)), 32'd0);
            chk($sformatf("rst_s_d%0d", sel),    32'(f_s(sel)),    32'd0);
            chk($sformatf("rst_cout_d%0d", sel), 32'(f_cout(sel)), 32'd0);
            chk($sformatf("rst_ovf_d%0d", sel),  32'(f_ovf(sel)),  32'd0);
        end
        rst = 1'b0;

        do_op(4, "add_3c_45", 1'b0, 8'h3C, 8'h45, 1'b0);
        do_op(4, "sub_10_20", 1'b1, 8'h10, 8'h20, 1'b0);
        do_op(4, "sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0);
        do_op(4, "carry_d4",  1'b0, 8'hFF, 8'h01, 1'b1);
        do_op(1, "carry_d1",  1'b0, 8'hFF, 8'h01, 1'b1);
        do_op(8, "d8_7f_01",  1'b0, 8'h7F, 8'h01, 1'b0);

        // Reset during RUN aborts the operation without a done pulse.
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
        chk("abort_busy_c1", 32'(f_busy(4)), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy_c2", 32'(f_busy(4)), 32'd0);
        chk("abort_done_c2", 32'(f_done(4)), 32'd0);
        chk("abort_s_c2",    32'(f_s(4)),    32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone_%0d", k), 32'(f_done(4)), 32'd0);
        end

        // Start held high: one operation per NUM+2 = 4 cycles, noise on operands while busy.
        ndone = 0;
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 8'h01, 8'h02, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (f_done(4)) ndone++;
            chk($sformatf("hs_done_c%0d", k), 32'(f_done(4)), 32'((k % 4) == 3));
            chk($sformatf("hs_busy_c%0d", k), 32'(f_busy(4)), 32'((k % 4) == 1 || (k % 4) == 2));
            if (k >= 3) chk($sformatf("hs_s_c%0d", k), 32'(f_s(4)), 32'h03);
            if ((k % 4) == 0 && k < 12) drive(4, 1'b1, 1'b0, 8'h01, 8'h02, 1'b0);
            else if (k < 12) drive(4, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            else drive(4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
        chk("hs_done_count", 32'(ndone), 32'd3);
        repeat (6) @(negedge clk);

        // Random operations across all three digit sizes.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0: sel = 1;
                1: sel = 4;
                default: sel = 8;
            endcase
            do_op(sel, $sformatf("rnd%0d_d%0d", n, sel), 1'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
